// File: rtl/fp_pkg.sv
// Shared constants and FSM state encoding for the FP32 multiplier round/pack back end.
package fp_pkg;

   localparam int unsigned EXP_W   = 8;
   localparam int unsigned MAN_W   = 23;
   localparam int unsigned BIAS    = 127;
   localparam int unsigned EXP_MAX = 2 * BIAS + 1;
   localparam int unsigned PW      = 2 * (MAN_W + 1);
   localparam int unsigned EW      = EXP_W + 2;
   localparam logic [31:0] QNAN    = 32'h7FC0_0000;

   typedef enum logic [2:0] {
      IDLE,
      NORM,
      DENORM,
      ROUND,
      HOLD
   } state_t;

endpackage

// File: rtl/fp_rne_rounder.sv
// Combinational round-to-nearest-even on a 24-bit significand with exponent carry adjust.
module fp_rne_rounder #(
   parameter int unsigned MAN_W = 23,
   parameter int unsigned EW    = 10
) (
   input  logic                 i_hidden,
   input  logic [MAN_W-1:0]     i_frac,
   input  logic                 i_g,
   input  logic                 i_r,
   input  logic                 i_s,
   input  logic signed [EW-1:0] i_e,
   output logic [MAN_W:0]       o_mant,
   output logic signed [EW-1:0] o_e,
   output logic                 o_inexact
);

   localparam logic signed [EW-1:0] LP_E_ONE = EW'(1);

   logic             w_inc;
   logic [MAN_W+1:0] w_sum;

   assign w_inc     = i_g & (i_r | i_s | i_frac[0]);
   assign w_sum     = {1'b0, i_hidden, i_frac} + {{(MAN_W + 1){1'b0}}, w_inc};
   assign o_inexact = i_g | i_r | i_s;

   always_comb begin
      o_mant = w_sum[MAN_W:0];
      o_e    = i_e;
      // Carry out of the 24-bit significand: renormalize to 1.0 and bump exponent.
      if (w_sum[MAN_W+1]) begin
         o_mant = {1'b1, {MAN_W{1'b0}}};
         o_e    = i_e + LP_E_ONE;
      end
   end

endmodule

// File: rtl/fp_round_pack_unit.sv
// FP32 multiplier back end: serial renormalize/denormalize, RNE rounding and IEEE-754 packing.
module fp_round_pack_unit #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23,
   parameter int unsigned BIAS  = 127
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_in_valid,
   output logic                         o_in_ready,
   input  logic                         i_in_sign,
   input  logic [2*(MAN_W+1)-1:0]       i_in_prod,
   input  logic signed [EXP_W+1:0]      i_in_exp_sum,
   input  logic                         i_in_nan,
   input  logic                         i_in_inf,
   input  logic                         i_in_zero,
   output logic                         o_out_valid,
   input  logic                         i_out_ready,
   output logic [EXP_W+MAN_W:0]         o_out_result,
   output logic                         o_out_overflow,
   output logic                         o_out_underflow,
   output logic                         o_out_inexact
);

   import fp_pkg::*;

   localparam int unsigned LP_PW   = 2 * (MAN_W + 1);
   localparam int unsigned LP_EW   = EXP_W + 2;
   localparam int unsigned LP_EMAX = 2 * BIAS + 1;
   localparam int          LP_DMIN = -(MAN_W + 1);

   localparam logic signed [LP_EW-1:0] LP_E_ONE  = LP_EW'(1);
   localparam logic signed [LP_EW-1:0] LP_E_DMIN = LP_EW'(LP_DMIN);
   localparam logic signed [LP_EW-1:0] LP_E_MAX  = LP_EW'(LP_EMAX);

   localparam logic [EXP_W+MAN_W:0] LP_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

   state_t                    r_state;
   logic [LP_PW-1:0]          r_m;
   logic signed [LP_EW-1:0]   r_e;
   logic                      r_sticky;
   logic                      r_sign;
   logic                      r_nan;
   logic                      r_inf;
   logic                      r_zero;
   logic                      r_valid;
   logic [EXP_W+MAN_W:0]      r_result;
   logic                      r_ovf;
   logic                      r_unf;
   logic                      r_inx;

   logic                      w_prod_zero;
   logic                      w_special;
   logic [MAN_W:0]            w_mant;
   logic signed [LP_EW-1:0]   w_e_rnd;
   logic                      w_rnd_inx;
   logic [EXP_W-1:0]          w_exp_field;
   logic [EXP_W+MAN_W:0]      w_result;
   logic                      w_ovf;
   logic                      w_unf;
   logic                      w_inx;

   assign w_prod_zero = (i_in_prod == '0);
   assign w_special   = i_in_nan | i_in_inf | i_in_zero | w_prod_zero;

   fp_rne_rounder #(
      .MAN_W (MAN_W),
      .EW    (LP_EW)
   ) u_rounder (
      .i_hidden  (r_m[LP_PW-2]),
      .i_frac    (r_m[LP_PW-3 -: MAN_W]),
      .i_g       (r_m[MAN_W-1]),
      .i_r       (r_m[MAN_W-2]),
      .i_s       ((|r_m[MAN_W-3:0]) | r_sticky),
      .i_e       (r_e),
      .o_mant    (w_mant),
      .o_e       (w_e_rnd),
      .o_inexact (w_rnd_inx)
   );

   assign w_exp_field = w_mant[MAN_W] ? w_e_rnd[EXP_W-1:0] : '0;

   always_comb begin
      w_result = '0;
      w_ovf    = 1'b0;
      w_unf    = 1'b0;
      w_inx    = 1'b0;
      if (r_nan) begin
         w_result = LP_QNAN;
      end else if (r_inf) begin
         w_result = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (r_zero) begin
         w_result = {r_sign, {(EXP_W + MAN_W){1'b0}}};
      end else if (w_e_rnd >= LP_E_MAX) begin
         w_result = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         w_ovf    = 1'b1;
         w_inx    = 1'b1;
      end else begin
         w_result = {r_sign, w_exp_field, w_mant[MAN_W-1:0]};
         w_inx    = w_rnd_inx;
         w_unf    = (w_exp_field == '0) & w_rnd_inx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_m      <= '0;
         r_e      <= '0;
         r_sticky <= 1'b0;
         r_sign   <= 1'b0;
         r_nan    <= 1'b0;
         r_inf    <= 1'b0;
         r_zero   <= 1'b0;
         r_valid  <= 1'b0;
         r_result <= '0;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
         r_inx    <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (i_in_valid) begin
                  r_m      <= i_in_prod;
                  r_e      <= i_in_exp_sum;
                  r_sticky <= 1'b0;
                  r_sign   <= i_in_sign;
                  r_nan    <= i_in_nan;
                  r_inf    <= i_in_inf;
                  r_zero   <= i_in_zero | w_prod_zero;
                  r_state  <= w_special ? ROUND : NORM;
               end
            end
            NORM: begin
               if (r_m[LP_PW-1]) begin
                  r_m      <= r_m >> 1;
                  r_sticky <= r_sticky | r_m[0];
                  r_e      <= r_e + LP_E_ONE;
                  r_state  <= DENORM;
               end else if (!r_m[LP_PW-2] && (r_e > LP_E_ONE)) begin
                  r_m <= r_m << 1;
                  r_e <= r_e - LP_E_ONE;
               end else begin
                  r_state <= DENORM;
               end
            end
            DENORM: begin
               if (r_e >= LP_E_ONE) begin
                  r_state <= ROUND;
               end else if (r_e >= LP_E_DMIN) begin
                  r_m      <= r_m >> 1;
                  r_sticky <= r_sticky | r_m[0];
                  r_e      <= r_e + LP_E_ONE;
               end else begin
                  // Far below the denormal range: everything becomes sticky in one step.
                  r_sticky <= r_sticky | (|r_m);
                  r_m      <= '0;
                  r_e      <= LP_E_ONE;
               end
            end
            ROUND: begin
               r_result <= w_result;
               r_ovf    <= w_ovf;
               r_unf    <= w_unf;
               r_inx    <= w_inx;
               r_valid  <= 1'b1;
               r_state  <= HOLD;
            end
            HOLD: begin
               if (i_out_ready) begin
                  r_valid <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_in_ready      = (r_state == IDLE);
   assign o_out_valid     = r_valid;
   assign o_out_result    = r_result;
   assign o_out_overflow  = r_ovf;
   assign o_out_underflow = r_unf;
   assign o_out_inexact   = r_inx;

endmodule
